dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between a data-memory initiator and
//               the dmem_responder target.
//   Initiator -> target : req, we, addr[7:0], siz[1:0], se, wdata[31:0]
//   Target -> initiator : rdata[31:0], ack, busy, wea[3:0], err
//   master modport = initiator side, slave modport = responder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [1:0]  siz;
  logic        se;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic [3:0]  wea;
  logic        err;

  modport master (
    output req, we, addr, siz, se, wdata,
    input  rdata, ack, busy, wea, err
  );

  modport slave (
    input  req, we, addr, siz, se, wdata,
    output rdata, ack, busy, wea, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-port 32-bit data memory target with programmable wait
//               states, byte/half/word access, sign/zero extension on loads
//               and rejection of misaligned or illegal-size commands.
//   clk   : clock, rising edge active
//   rst_  : asynchronous active-low reset
//   bus   : dmem_responder_if.slave (command in, rdata/ack/busy/wea/err out)
// Parameters:
//   WAIT_CYCLES : wait states before each access (0..15)
//   DEPTH       : number of 32-bit words (1..64), word index = addr[7:2]
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 64
) (
  input  wire logic        clk,
  input  wire logic        rst_,
  dmem_responder_if.slave  bus
);

  // Only addr[7:2] is available as an index, so more than 64 words
  // could never be addressed.
  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] DEPTH_W = 7'(DEPTH);
  localparam logic [3:0] WAIT_W  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        we_q,    we_d;
  logic [7:0]  addr_q,  addr_d;
  logic [1:0]  siz_q,   siz_d;
  logic        se_q,    se_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bad_q,   bad_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wea_q,   wea_d;

  logic [31:0] mem_q [0:DEPTH-1];

  logic          w_cmd_bad;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_lane_we;
  logic [31:0]   w_lane_data;
  logic          w_mem_we;

  // Misalignment is judged on the live command so a rejected access can
  // skip the wait/access phases entirely.
  assign w_cmd_bad = (bus.siz == 2'd3)
                   | ((bus.siz == 2'd1) & bus.addr[0])
                   | ((bus.siz == 2'd2) & (bus.addr[1:0] != 2'b00));

  // Word index wraps modulo DEPTH so non power-of-two depths alias cleanly.
  assign w_idx  = IW'({1'b0, addr_q[7:2]} % DEPTH_W);
  assign w_word = mem_q[w_idx];
  assign w_byte = w_word[{addr_q[1:0], 3'b000} +: 8];
  assign w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];

  // Store lane enables and lane-replicated write data; only enabled lanes
  // actually land in storage.
  always_comb begin
    w_lane_we   = 4'b1111;
    w_lane_data = wdata_q;
    case (siz_q)
      2'd0: begin
        w_lane_we   = 4'b0001 << addr_q[1:0];
        w_lane_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        w_lane_we   = addr_q[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        w_lane_we   = 4'b1111;
        w_lane_data = wdata_q;
      end
    endcase
  end

  // Right-aligned load result; se only matters for sub-word sizes.
  always_comb begin
    w_load = w_word;
    case (siz_q)
      2'd0:    w_load = {{24{se_q & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{se_q & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    siz_d    = siz_q;
    se_d     = se_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    rdata_d  = rdata_q;
    wea_d    = wea_q;
    w_mem_we = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          siz_d   = bus.siz;
          se_d    = bus.se;
          wdata_d = bus.wdata;
          bad_d   = w_cmd_bad;
          if (w_cmd_bad) begin
            state_d = S_RESP;
          end else if (WAIT_W != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_W;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end

      S_WAIT: begin
        // Counter holds the number of WAIT cycles still to spend,
        // including the current one.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        if (we_q) begin
          w_mem_we = 1'b1;
          wea_d    = w_lane_we;
        end else begin
          rdata_d = w_load;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      siz_q   <= 2'd0;
      se_q    <= 1'b0;
      wdata_q <= 32'd0;
      bad_q   <= 1'b0;
      rdata_q <= 32'd0;
      wea_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      siz_q   <= siz_d;
      se_q    <= se_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      wea_q   <= wea_d;
    end
  end

  // Storage is not reset. An asserted reset forces state_q to IDLE, which
  // drops w_mem_we, so a reset before the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_we[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.wea   = wea_q;
  assign bus.ack   = (state_q == S_RESP);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.err   = (state_q == S_RESP) & bad_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder. Unit 0 is built with
//               WAIT_CYCLES=1/DEPTH=64, unit 1 with WAIT_CYCLES=0/DEPTH=16.
//               Expected responses are queued when a command is accepted and
//               compared when ack is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  typedef struct {
    longint      acc;
    int          lat;
    logic [31:0] rd;
    logic [3:0]  wea;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.WAIT_CYCLES(1), .DEPTH(64)) u_dut0 (
    .clk (clk),
    .rst_(rst_),
    .bus (bus0.slave)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH(16)) u_dut1 (
    .clk (clk),
    .rst_(rst_),
    .bus (bus1.slave)
  );

  int          n_vec = 0;
  int          n_mis = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int          c_wait [2] = '{1, 0};
  int          c_depth[2] = '{64, 16};
  logic [31:0] m_mem  [2][64];
  logic [31:0] m_rdata[2];
  logic [3:0]  m_wea  [2];
  longint      prev_acc[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int u);
    return (u == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic bad_cmd(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic drive(input int u, input logic rq, input logic we, input logic [7:0] a,
                       input logic [1:0] sz, input logic se, input logic [31:0] wd);
    if (u == 0) begin
      bus0.req = rq; bus0.we = we; bus0.addr = a; bus0.siz = sz; bus0.se = se; bus0.wdata = wd;
    end else begin
      bus1.req = rq; bus1.we = we; bus1.addr = a; bus1.siz = sz; bus1.se = se; bus1.wdata = wd;
    end
  endtask

  task automatic wait_idle(input int u);
    int k = 0;
    while (busy_of(u) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy_of(u)) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  // Present a command (called just after a negedge), record the accept
  // edge, and queue the response the model predicts.
  // keep   : leave req high afterwards (next command already waiting)
  // spaced : check accept-to-accept distance against WAIT_CYCLES+3 cycles
  task automatic issue(input int u, input logic we, input logic [7:0] a, input logic [1:0] sz,
                       input logic se, input logic [31:0] wd, input bit keep, input bit spaced);
    exp_t        e;
    int          idx;
    logic [3:0]  lanes;
    logic [31:0] sh;
    logic [31:0] w;
    logic [31:0] v;
    drive(u, 1'b1, we, a, sz, se, wd);
    wait_idle(u);
    @(posedge clk);
    e.acc = $time;
    if (spaced) check_eq("accept_spacing", 32'(e.acc - prev_acc[u]), 32'((c_wait[u] + 3) * 10));
    prev_acc[u] = e.acc;
    idx = int'(a[7:2]) % c_depth[u];
    if (bad_cmd(sz, a)) begin
      e.lat = 1;
      e.err = 1'b1;
    end else begin
      e.lat = c_wait[u] + 2;
      e.err = 1'b0;
      if (we) begin
        case (sz)
          2'd0: begin lanes = 4'b0001 << a[1:0];     sh = 32'(wd[7:0])  << (8 * a[1:0]); end
          2'd1: begin lanes = 4'b0011 << (2 * a[1]); sh = 32'(wd[15:0]) << (16 * a[1]); end
          default: begin lanes = 4'b1111; sh = wd; end
        endcase
        for (int b = 0; b < 4; b++)
          if (lanes[b]) m_mem[u][idx][8*b +: 8] = sh[8*b +: 8];
        m_wea[u] = lanes;
      end else begin
        w = m_mem[u][idx];
        case (sz)
          2'd0: begin
            v = (w >> (8 * a[1:0])) & 32'h0000_00FF;
            if (se && v[7]) v = v | 32'hFFFF_FF00;
          end
          2'd1: begin
            v = (w >> (16 * a[1])) & 32'h0000_FFFF;
            if (se && v[15]) v = v | 32'hFFFF_0000;
          end
          default: v = w;
        endcase
        m_rdata[u] = v;
      end
    end
    e.rd  = m_rdata[u];
    e.wea = m_wea[u];
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (!keep) drive(u, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic drain(input int u);
    int k = 0;
    while (qsize(u) != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (qsize(u) != 0) begin
      check_eq("drain_timeout", 32'(qsize(u)), 32'd0);
      if (u == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic score(input int u, input logic ack, input logic [31:0] rd,
                       input logic [3:0] wea, input logic err);
    exp_t e;
    if (ack) begin
      if (qsize(u) == 0) begin
        check_eq("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        check_eq("ack_latency", 32'(($time - e.acc + 5) / 10), 32'(e.lat));
        check_eq("rdata", rd, e.rd);
        check_eq("wea", 32'(wea), 32'(e.wea));
        check_eq("err", 32'(err), 32'(e.err));
      end
    end else begin
      check_eq("err_without_ack", 32'(err), 32'd0);
    end
  endtask

  always @(negedge clk) score(0, bus0.ack, bus0.rdata, bus0.wea, bus0.err);
  always @(negedge clk) score(1, bus1.ack, bus1.rdata, bus1.wea, bus1.err);

  initial begin
    rst_ = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
    for (int u = 0; u < 2; u++) begin
      m_rdata[u] = 32'h0; m_wea[u] = 4'h0; prev_acc[u] = 0;
    end
    #1;
    check_eq("rst_ack",   32'(bus0.ack),  32'd0);
    check_eq("rst_busy",  32'(bus0.busy), 32'd0);
    check_eq("rst_err",   32'(bus0.err),  32'd0);
    check_eq("rst_rdata", bus0.rdata,     32'd0);
    check_eq("rst_wea",   32'(bus0.wea),  32'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    // Word store / load round trip
    issue(0, 1'b1, 8'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drain(0);
    check_eq("word_store_wea", 32'(bus0.wea), 32'h0000_000F);
    issue(0, 1'b0, 8'h10, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("word_load_data", bus0.rdata, 32'hDEAD_BEEF);

    // Byte store into a cleared word, signed and unsigned reloads
    issue(0, 1'b1, 8'h10, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    issue(0, 1'b1, 8'h13, 2'd0, 1'b0, 32'h0000_0080, 1'b0, 1'b0);
    drain(0);
    check_eq("byte_store_wea", 32'(bus0.wea), 32'h0000_0008);
    issue(0, 1'b0, 8'h13, 2'd0, 1'b1, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("byte_load_sext", bus0.rdata, 32'hFFFF_FF80);
    issue(0, 1'b0, 8'h13, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("byte_load_zext", bus0.rdata, 32'h0000_0080);
    issue(0, 1'b0, 8'h12, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("half_load_sext", bus0.rdata, 32'hFFFF_8000);

    // Rejected commands: misaligned half/word, misaligned store, siz=3
    issue(0, 1'b0, 8'h11, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(0, 1'b0, 8'h12, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(0, 1'b1, 8'h11, 2'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(0, 1'b0, 8'h10, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("err_keeps_rdata", bus0.rdata, 32'hFFFF_8000);
    check_eq("err_keeps_wea", 32'(bus0.wea), 32'h0000_0008);
    issue(0, 1'b0, 8'h10, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("err_keeps_storage", bus0.rdata, 32'h8000_0000);

    // req held high across three stores
    issue(0, 1'b1, 8'h30, 2'd0, 1'b0, 32'h0000_0011, 1'b1, 1'b0);
    issue(0, 1'b1, 8'h32, 2'd1, 1'b0, 32'h0000_2233, 1'b1, 1'b1);
    issue(0, 1'b1, 8'h31, 2'd0, 1'b0, 32'h0000_0044, 1'b0, 1'b1);
    drain(0);
    check_eq("held_last_wea", 32'(bus0.wea), 32'h0000_0002);
    issue(0, 1'b0, 8'h30, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("held_merge", bus0.rdata, 32'h2233_4411);

    // Reset during WAIT aborts the store
    issue(0, 1'b1, 8'h20, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    drain(0);
    wait_idle(0);
    drive(0, 1'b1, 1'b1, 8'h20, 2'd2, 1'b0, 32'hAAAA_AAAA);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
    check_eq("busy_in_wait", 32'(bus0.busy), 32'd1);
    rst_ = 1'b0;
    #1;
    check_eq("abort_ack",   32'(bus0.ack),  32'd0);
    check_eq("abort_busy",  32'(bus0.busy), 32'd0);
    check_eq("abort_err",   32'(bus0.err),  32'd0);
    check_eq("abort_rdata", bus0.rdata,     32'd0);
    check_eq("abort_wea",   32'(bus0.wea),  32'd0);
    for (int u = 0; u < 2; u++) begin
      m_rdata[u] = 32'h0; m_wea[u] = 4'h0;
    end
    @(negedge clk);
    rst_ = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 1'b0, 8'h20, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(0);
    check_eq("abort_no_write", bus0.rdata, 32'h1234_5678);

    // Zero wait states, 16-word depth with index wrap
    issue(1, 1'b1, 8'h04, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
    issue(1, 1'b0, 8'h44, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(1);
    check_eq("w0_wrap_load", bus1.rdata, 32'hCAFE_F00D);
    issue(1, 1'b0, 8'h45, 2'd0, 1'b1, 32'h0, 1'b1, 1'b0);
    issue(1, 1'b0, 8'h06, 2'd1, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(1, 1'b0, 8'h04, 2'd3, 1'b0, 32'h0, 1'b0, 1'b0);
    drain(1);
    check_eq("w0_half_zext", bus1.rdata, 32'h0000_CAFE);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
